// File: rtl/ws2812b_frame_seq_if.sv
// Bundle between the frame sequencer, its host (pixel writes, start) and the bit encoder.
// The master side drives writes, start and the encoder's px_done. The slave is the sequencer.
interface ws2812b_frame_seq_if #(
    parameter int NUM_LEDS = 8
);
    localparam int ADDR_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [23:0]       wr_data;
    logic              start;
    logic              busy;
    logic              frame_done;
    logic              px_en;
    logic [7:0]        px_r;
    logic [7:0]        px_g;
    logic [7:0]        px_b;
    logic              px_done;

    modport master (
        output wr_en, wr_addr, wr_data, start, px_done,
        input  busy, frame_done, px_en, px_r, px_g, px_b
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, px_done,
        output busy, frame_done, px_en, px_r, px_g, px_b
    );
endinterface

// File: rtl/ws2812b_frame_seq.sv
// Frame sequencer: holds NUM_LEDS colour words and streams them to the ws2812b encoder
// one pixel per px_done, then holds the line idle for the latch gap before frame_done.
module ws2812b_frame_seq #(
    parameter int NUM_LEDS = 8,
    parameter int CLK_HZ   = 50_000_000,
    parameter int LATCH_US = 300
) (
    input logic               clock_i,
    input logic               reset_n_i,
    ws2812b_frame_seq_if.slave bus
);
    localparam int LATCH_CYC = CLK_HZ / 1_000_000 * LATCH_US;
    localparam int ADDR_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int DEPTH     = 1 << ADDR_W;
    localparam int CNT_W     = $clog2(LATCH_CYC + 1);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_LEDS - 1);
    localparam logic [CNT_W-1:0]  CNT_END  = CNT_W'(LATCH_CYC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        LATCH = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic              px_en_q, px_en_d;
    logic [23:0]       word_q, word_d;

    logic [23:0]       ram_q [DEPTH];
    logic [ADDR_W-1:0] load_idx;
    logic [23:0]       load_word;

    // Pixel store needs an async clear, so it is built from flops rather than block RAM.
    // Slots past NUM_LEDS (power-of-two padding) never accept writes and read as zero.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ram
            if (gi < NUM_LEDS) begin : g_used
                always_ff @(posedge clock_i or negedge reset_n_i) begin
                    if (!reset_n_i) begin
                        ram_q[gi] <= '0;
                    end else if (bus.wr_en && (bus.wr_addr == ADDR_W'(gi))) begin
                        ram_q[gi] <= bus.wr_data;
                    end
                end
            end else begin : g_pad
                always_ff @(posedge clock_i or negedge reset_n_i) begin
                    if (!reset_n_i) begin
                        ram_q[gi] <= '0;
                    end else begin
                        ram_q[gi] <= '0;
                    end
                end
            end
        end
    endgenerate

    // A write landing on the very word being loaded is forwarded, so the newest value goes out.
    always_comb begin
        load_idx  = (state_q == IDLE) ? '0 : index_q + 1'b1;
        load_word = (bus.wr_en && (bus.wr_addr == load_idx)) ? bus.wr_data : ram_q[load_idx];
    end

    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        count_d      = count_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        px_en_d      = px_en_q;
        word_d       = word_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SEND;
                    index_d = '0;
                    busy_d  = 1'b1;
                    px_en_d = 1'b1;
                    word_d  = load_word;
                end
            end
            SEND: begin
                if (bus.px_done) begin
                    if (index_q == LAST_IDX) begin
                        state_d = LATCH;
                        px_en_d = 1'b0;
                        count_d = '0;
                    end else begin
                        index_d = index_q + 1'b1;
                        word_d  = load_word;
                    end
                end
            end
            LATCH: begin
                count_d = count_q + 1'b1;
                if (count_q == CNT_END) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                    busy_d       = 1'b0;
                    count_d      = '0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                px_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= IDLE;
            index_q      <= '0;
            count_q      <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            px_en_q      <= 1'b0;
            word_q       <= '0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            count_q      <= count_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            px_en_q      <= px_en_d;
            word_q       <= word_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.px_en      = px_en_q;
    assign bus.px_r       = word_q[23:16];
    assign bus.px_g       = word_q[15:8];
    assign bus.px_b       = word_q[7:0];
endmodule

// File: tb/tb_ws2812b_frame_seq.sv
// Bench for ws2812b_frame_seq: a 4-pixel instance driven through full frames with a
// scoreboard of presented words, plus a 1-pixel instance for the single-pixel and addressing cases.
module tb_ws2812b_frame_seq;
    localparam int N         = 4;
    localparam int CLK_HZ    = 1_000_000;
    localparam int LATCH_US  = 20;
    localparam int LATCH_CYC = 20;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    ws2812b_frame_seq_if #(.NUM_LEDS(N)) bus ();
    ws2812b_frame_seq_if #(.NUM_LEDS(1)) bus1 ();

    ws2812b_frame_seq #(.NUM_LEDS(N), .CLK_HZ(CLK_HZ), .LATCH_US(LATCH_US)) u_dut (
        .clock_i  (clk),
        .reset_n_i(rst_n),
        .bus      (bus)
    );

    ws2812b_frame_seq #(.NUM_LEDS(1), .CLK_HZ(CLK_HZ), .LATCH_US(LATCH_US)) u_dut1 (
        .clock_i  (clk),
        .reset_n_i(rst_n),
        .bus      (bus1)
    );

    typedef struct {
        logic [1:0]  addr;
        logic [23:0] data;
        logic [23:0] exp;
    } vec_t;

    vec_t        vecs [N];
    logic [23:0] model [N];
    logic [23:0] exp_q [$];
    int          checks   = 0;
    int          failures = 0;
    logic        px_en_prev = 1'b0;
    logic        pd_prev    = 1'b0;

    function automatic logic [23:0] word4();
        return {bus.px_r, bus.px_g, bus.px_b};
    endfunction

    function automatic logic [23:0] word1();
        return {bus1.px_r, bus1.px_g, bus1.px_b};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [23:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        model[a]    = d;
        @(posedge clk); #1;
        bus.wr_en   = 1'b0;
    endtask

    // Encoder model: one pixel takes 30 cycles, then px_done for one cycle.
    task automatic pulse_done(input bit push, input logic [23:0] nxt);
        repeat (29) @(posedge clk);
        #1;
        bus.px_done = 1'b1;
        if (push) exp_q.push_back(nxt);
        @(posedge clk); #1;
        bus.px_done = 1'b0;
    endtask

    task automatic wait_frame_done(input string name, input bit sel, input bit poke, input bit chain);
        int cyc   = 0;
        bit found = 1'b0;
        while (!found && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            found = sel ? bus1.frame_done : bus.frame_done;
            if (poke && cyc == 5) begin
                bus.start   = 1'b1;
                bus.px_done = 1'b1;
            end
            if (poke && cyc == 6) begin
                bus.start   = 1'b0;
                bus.px_done = 1'b0;
            end
            if (poke && cyc == 8) begin
                check("latch_stray_px_en", bus.px_en, 0);
                check("latch_stray_busy", bus.busy, 1);
            end
        end
        check(name, cyc, LATCH_CYC);
        if (found) begin
            check({name, "_busy_off"}, sel ? bus1.busy : bus.busy, 0);
            if (chain) begin
                bus.start = 1'b1;
                exp_q.push_back(model[0]);
            end
        end
    endtask

    // Scoreboard consumer: a new word appears when px_en rises or the cycle after px_done.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.px_en && (!px_en_prev || pd_prev)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL px_word unexpected actual=%06h required=none", word4());
                end else begin
                    check("px_word", 32'(word4()), 32'(exp_q.pop_front()));
                end
            end
            px_en_prev = bus.px_en;
            pd_prev    = bus.px_done;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{addr: 2'd0, data: 24'h110000, exp: 24'h110000};
        vecs[1] = '{addr: 2'd1, data: 24'h002200, exp: 24'h002200};
        vecs[2] = '{addr: 2'd2, data: 24'h000033, exp: 24'h000033};
        vecs[3] = '{addr: 2'd3, data: 24'hABCDEF, exp: 24'hABCDEF};
        for (int i = 0; i < N; i++) model[i] = '0;

        bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.start = 0; bus.px_done = 0;
        bus1.wr_en = 0; bus1.wr_addr = '0; bus1.wr_data = '0; bus1.start = 0; bus1.px_done = 0;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset_busy", bus.busy, 0);
        check("reset_px_en", bus.px_en, 0);
        check("reset_frame_done", bus.frame_done, 0);
        check("reset_word", word4(), 0);

        // Single-pixel build; address 1 is out of range there and must be dropped.
        bus1.wr_en = 1; bus1.wr_addr = 1'b0; bus1.wr_data = 24'hA5A5A5;
        @(posedge clk); #1;
        bus1.wr_addr = 1'b1; bus1.wr_data = 24'h5A5A5A;
        @(posedge clk); #1;
        bus1.wr_en = 0;
        bus1.start = 1;
        @(posedge clk); #1;
        bus1.start = 0;
        check("n1_busy", bus1.busy, 1);
        check("n1_px_en", bus1.px_en, 1);
        check("n1_word", word1(), 24'hA5A5A5);
        repeat (3) @(posedge clk);
        #1 bus1.px_done = 1;
        @(posedge clk); #1;
        bus1.px_done = 0;
        check("n1_px_en_off", bus1.px_en, 0);
        check("n1_busy_latch", bus1.busy, 1);
        wait_frame_done("n1_latch_len", 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        bus1.start = 1;
        @(posedge clk); #1;
        bus1.start = 0;
        check("n1_oob_write_ignored", word1(), 24'hA5A5A5);
        #1 bus1.px_done = 1;
        @(posedge clk); #1;
        bus1.px_done = 0;
        wait_frame_done("n1_latch_len2", 1'b1, 1'b0, 1'b0);

        // Frame 1 from the vector table; start pulses during SEND and LATCH must be ignored.
        for (int i = 0; i < N; i++) wr(vecs[i].addr, vecs[i].data);
        bus.start = 1;
        exp_q.push_back(model[0]);
        @(posedge clk); #1;
        bus.start = 0;
        check("start_busy", bus.busy, 1);
        check("start_px_en", bus.px_en, 1);
        for (int i = 1; i < N; i++) begin
            pulse_done(1'b1, vecs[i].exp);
            if (i == 1) begin
                bus.start = 1;
                @(posedge clk); #1;
                bus.start = 0;
                check("start_in_send_word", word4(), vecs[1].exp);
                check("start_in_send_px_en", bus.px_en, 1);
            end
        end
        pulse_done(1'b0, 24'h0);
        check("px_en_fall", bus.px_en, 0);
        check("busy_in_latch", bus.busy, 1);
        wait_frame_done("frame1_latch_len", 1'b0, 1'b1, 1'b1);
        @(posedge clk); #1;
        bus.start = 0;
        check("frame_done_width", bus.frame_done, 0);
        check("restart_on_done", bus.busy, 1);

        // Frame 2: rewrite the pixel in flight and the next one.
        pulse_done(1'b1, model[1]);
        wr(2'd1, 24'hFFFFFF);
        wr(2'd2, 24'h123456);
        check("inflight_px1_held", word4(), vecs[1].exp);
        pulse_done(1'b1, model[2]);
        pulse_done(1'b1, model[3]);
        pulse_done(1'b0, 24'h0);
        wait_frame_done("frame2_latch_len", 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("frame2_done_width", bus.frame_done, 0);

        // Stray px_done in IDLE.
        bus.px_done = 1;
        @(posedge clk); #1;
        bus.px_done = 0;
        @(posedge clk); #1;
        check("idle_stray_busy", bus.busy, 0);
        check("idle_stray_px_en", bus.px_en, 0);
        check("idle_stray_word", word4(), model[3]);

        // Frame 3, aborted by reset during SEND.
        bus.start = 1;
        exp_q.push_back(model[0]);
        @(posedge clk); #1;
        bus.start = 0;
        pulse_done(1'b1, model[1]);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_px_en", bus.px_en, 0);
        check("async_rst_busy", bus.busy, 0);
        check("async_rst_word", word4(), 0);
        exp_q.delete();
        for (int i = 0; i < N; i++) model[i] = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Frame 4: RAM must read back as cleared.
        bus.start = 1;
        exp_q.push_back(model[0]);
        @(posedge clk); #1;
        bus.start = 0;
        for (int i = 1; i < N; i++) pulse_done(1'b1, model[i]);
        pulse_done(1'b0, 24'h0);
        wait_frame_done("frame4_latch_len", 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
